// File: rtl/conv_sched_if.sv
// Bus between the convolution sequencer, the pixel memory, the MAC and the writeback stage.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface conv_sched_if #(
  parameter int IMG_LOG2 = 6,
  parameter int DATA_W   = 16
);
  localparam int AW = 2 * IMG_LOG2;

  logic                ready;
  logic                busy;
  logic [AW-1:0]       iaddr;
  logic [DATA_W-1:0]   idata;
  logic [3:0]          cnt_pixel;
  logic [DATA_W-1:0]   pi0;
  logic [DATA_W-1:0]   pi1;
  logic [DATA_W-1:0]   pi2;
  logic [IMG_LOG2-1:0] cnt_length;
  logic [IMG_LOG2-1:0] cnt_width;
  logic                flag_corner;
  logic                flag_upbot;
  logic                flag_lfri;
  logic                conv_valid;
  logic [AW-1:0]       conv_addr;
  logic                out_ready;
  logic                done;

  modport master (
    input  ready, idata, out_ready,
    output busy, iaddr, cnt_pixel, pi0, pi1, pi2, cnt_length, cnt_width,
           flag_corner, flag_upbot, flag_lfri, conv_valid, conv_addr, done
  );

  modport slave (
    output ready, idata, out_ready,
    input  busy, iaddr, cnt_pixel, pi0, pi1, pi2, cnt_length, cnt_width,
           flag_corner, flag_upbot, flag_lfri, conv_valid, conv_addr, done
  );
endinterface

// File: rtl/conv_sched.sv
// Raster-order sequencer for the two-kernel 3x3 convolution MAC: fetches the in-image
// window taps column-major, packs them into pi0..pi2 and hands each result to writeback.
module conv_sched #(
  parameter int IMG_LOG2 = 6,
  parameter int DATA_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  conv_sched_if.master bus
);
  localparam int AW = 2 * IMG_LOG2;
  localparam logic [IMG_LOG2-1:0] LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_LATCH, S_OUT, S_DONE} state_t;

  state_t              state_q;
  logic [IMG_LOG2-1:0] row_q, col_q, tr_q, tc_q;
  logic [3:0]          tap_q, ntap_q, cnt_q;
  logic [1:0]          slot_q;
  logic [AW-1:0]       iaddr_q;
  logic [DATA_W-1:0]   pi0_q, pi1_q, pi2_q;
  logic                corner_q, upbot_q, lfri_q, busy_q, valid_q, done_q;

  logic [IMG_LOG2-1:0] nrow_d, ncol_d, tr_d, tc_d;
  logic                last_pos, start_d, capture_d, redge_d, cedge_d;
  logic [3:0]          ntap_d;

  function automatic logic [IMG_LOG2-1:0] win_lo(input logic [IMG_LOG2-1:0] p);
    return (p == '0) ? p : p - 1'b1;
  endfunction

  function automatic logic [IMG_LOG2-1:0] win_hi(input logic [IMG_LOG2-1:0] p);
    return (p == LAST) ? p : p + 1'b1;
  endfunction

  // Position that the next FETCH will work on: origin from IDLE, raster successor from OUT.
  always_comb begin
    nrow_d = '0;
    ncol_d = '0;
    if (state_q == S_OUT) begin
      ncol_d = col_q + 1'b1;
      nrow_d = (col_q == LAST) ? row_q + 1'b1 : row_q;
    end
  end

  assign last_pos  = (row_q == LAST) && (col_q == LAST);
  assign start_d   = ((state_q == S_IDLE) && bus.ready) ||
                     ((state_q == S_OUT) && bus.out_ready && !last_pos);
  assign capture_d = (state_q == S_DRAIN) || ((state_q == S_FETCH) && (tap_q != 4'd1));
  assign redge_d   = (nrow_d == '0) || (nrow_d == LAST);
  assign cedge_d   = (ncol_d == '0) || (ncol_d == LAST);
  assign ntap_d    = (redge_d && cedge_d) ? 4'd4 : ((redge_d || cedge_d) ? 4'd6 : 4'd9);

  // Column-major walk of the clipped window: rows top to bottom, then next column.
  assign tr_d = (tr_q == win_hi(row_q)) ? win_lo(row_q) : tr_q + 1'b1;
  assign tc_d = (tr_q == win_hi(row_q)) ? tc_q + 1'b1 : tc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      tr_q     <= '0;
      tc_q     <= '0;
      tap_q    <= '0;
      ntap_q   <= '0;
      cnt_q    <= '0;
      slot_q   <= '0;
      iaddr_q  <= '0;
      pi0_q    <= '0;
      pi1_q    <= '0;
      pi2_q    <= '0;
      corner_q <= 1'b0;
      upbot_q  <= 1'b0;
      lfri_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Memory data lags iaddr by one cycle, so each capture belongs to the previous tap.
      if (capture_d) begin
        case (slot_q)
          2'd0:    pi0_q <= bus.idata;
          2'd1:    pi1_q <= bus.idata;
          default: pi2_q <= bus.idata;
        endcase
        cnt_q  <= cnt_q + 1'b1;
        slot_q <= (slot_q == 2'd2) ? 2'd0 : slot_q + 1'b1;
      end
      if (start_d) begin
        row_q    <= nrow_d;
        col_q    <= ncol_d;
        tr_q     <= win_lo(nrow_d);
        tc_q     <= win_lo(ncol_d);
        iaddr_q  <= {win_lo(nrow_d), win_lo(ncol_d)};
        tap_q    <= 4'd1;
        ntap_q   <= ntap_d;
        slot_q   <= 2'd0;
        corner_q <= redge_d && cedge_d;
        upbot_q  <= redge_d && !cedge_d;
        lfri_q   <= cedge_d && !redge_d;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.ready) begin
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (tap_q == ntap_q) begin
            iaddr_q <= '0;
            state_q <= S_DRAIN;
          end else begin
            tr_q    <= tr_d;
            tc_q    <= tc_d;
            iaddr_q <= {tr_d, tc_d};
            tap_q   <= tap_q + 1'b1;
          end
        end
        S_DRAIN: state_q <= S_LATCH;
        S_LATCH: begin
          cnt_q   <= '0;
          valid_q <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (last_pos) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              row_q    <= '0;
              col_q    <= '0;
              corner_q <= 1'b0;
              upbot_q  <= 1'b0;
              lfri_q   <= 1'b0;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.iaddr       = iaddr_q;
  assign bus.cnt_pixel   = cnt_q;
  assign bus.pi0         = pi0_q;
  assign bus.pi1         = pi1_q;
  assign bus.pi2         = pi2_q;
  assign bus.cnt_length  = row_q;
  assign bus.cnt_width   = col_q;
  assign bus.flag_corner = corner_q;
  assign bus.flag_upbot  = upbot_q;
  assign bus.flag_lfri   = lfri_q;
  assign bus.conv_valid  = valid_q;
  assign bus.conv_addr   = {row_q, col_q};
  assign bus.done        = done_q;
endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: a window model queues per-position expectations,
// a negedge monitor checks taps, captures and result handshakes against them.
module tb_conv_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_sched_if #(.IMG_LOG2(6), .DATA_W(16)) bus ();
  conv_sched #(.IMG_LOG2(6), .DATA_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [11:0]      addr;
    logic [2:0]       flags;
    logic [3:0]       n;
    logic [8:0][11:0] taps;
    logic [2:0][15:0] pi;
  } exp_t;

  logic [15:0] mem [4096];
  exp_t        exp_q [$];
  int          n_cmp = 0, n_fail = 0, n_hs = 0, n_done = 0;
  bit          rand_bp = 1'b0, bp_done = 1'b0;

  int               k_seen;
  logic [3:0]       prev_cp;
  logic [11:0]      ia1, ia2;
  exp_t             e_mon;
  logic [2:0][15:0] pis;

  always @(posedge clk) bus.idata <= mem[bus.iaddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic abort_run(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  // Window for (r,c): every in-image neighbour, kernel columns left to right, rows top to bottom.
  function automatic exp_t model(input int r, input int c);
    exp_t e;
    int   n;
    bit   re, ce;
    e  = '0;
    n  = 0;
    re = (r == 0) || (r == 63);
    ce = (c == 0) || (c == 63);
    e.addr  = 12'(r * 64 + c);
    e.flags = {re && ce, re && !ce, ce && !re};
    for (int dc = -1; dc <= 1; dc++) begin
      for (int dr = -1; dr <= 1; dr++) begin
        if (r + dr >= 0 && r + dr < 64 && c + dc >= 0 && c + dc < 64) begin
          e.taps[n]  = 12'((r + dr) * 64 + c + dc);
          e.pi[n % 3] = mem[(r + dr) * 64 + c + dc];
          n++;
        end
      end
    end
    e.n = 4'(n);
    return e;
  endfunction

  task automatic push_frame();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        exp_q.push_back(model(r, c));
  endtask

  task automatic pulse_ready();
    @(posedge clk); #2;
    bus.ready = 1'b1;
    @(posedge clk); #2;
    bus.ready = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_ctl"}, {bus.busy, bus.done, bus.conv_valid}, 0);
    chk({pfx, "_iaddr"}, bus.iaddr, 0);
    chk({pfx, "_cnt_pixel"}, bus.cnt_pixel, 0);
    chk({pfx, "_pi"}, {bus.pi0, bus.pi1, bus.pi2}, 0);
    chk({pfx, "_pos"}, {bus.cnt_length, bus.cnt_width}, 0);
    chk({pfx, "_flags"}, {bus.flag_corner, bus.flag_upbot, bus.flag_lfri}, 0);
    chk({pfx, "_conv_addr"}, bus.conv_addr, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      k_seen  = 0;
      prev_cp = '0;
      ia1     = '0;
      ia2     = '0;
    end else begin
      pis = {bus.pi2, bus.pi1, bus.pi0};
      if (bus.done) begin
        n_done++;
        chk("busy_at_done", bus.busy, 0);
      end
      if (bus.conv_valid) chk("out_quiet", {bus.cnt_pixel, bus.iaddr}, 0);
      if (bus.cnt_pixel != prev_cp && bus.cnt_pixel != 4'd0) begin
        k_seen++;
        if (exp_q.size() == 0) begin
          chk("tap_unexpected", bus.cnt_pixel, 0);
        end else begin
          e_mon = exp_q[0];
          chk("cnt_pixel", bus.cnt_pixel, 64'(k_seen));
          if (k_seen >= 1 && k_seen <= 9) chk("tap_addr", ia2, e_mon.taps[k_seen-1]);
          chk("pi_capture", pis[(k_seen-1) % 3], mem[ia2]);
          chk("fetch_pos", {bus.cnt_length, bus.cnt_width}, e_mon.addr);
          chk("fetch_flags", {bus.flag_corner, bus.flag_upbot, bus.flag_lfri}, e_mon.flags);
        end
      end
      if (bus.conv_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("result_unexpected", bus.conv_addr, 64'hFFFF);
        end else begin
          e_mon = exp_q.pop_front();
          chk("conv_addr", bus.conv_addr, e_mon.addr);
          chk("out_flags", {bus.flag_corner, bus.flag_upbot, bus.flag_lfri}, e_mon.flags);
          chk("out_pi", pis, e_mon.pi);
          chk("tap_count", 64'(k_seen), e_mon.n);
        end
        n_hs++;
        k_seen = 0;
      end
      prev_cp = bus.cnt_pixel;
      ia2 = ia1;
      ia1 = bus.iaddr;
    end
  end

  // Writeback side: a fixed 5-cycle stall at (2,2), otherwise optional random stalls.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (reset && bus.conv_valid && bus.conv_addr == 12'd130 && !bp_done) begin
        bp_done = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #2;
          chk("bp_hold", {bus.conv_valid, bus.conv_addr, bus.cnt_pixel, bus.iaddr},
              {1'b1, 12'd130, 4'd0, 12'd0});
        end
        bus.out_ready = 1'b1;
      end else begin
        bus.out_ready = rand_bp ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
    end
  end

  initial begin
    int cyc;
    bus.ready = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1 check_zero("por");
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 check_zero("idle");

    push_frame();
    pulse_ready();
    cyc = 0;
    while (!(bus.cnt_length == 6'd30 && bus.cnt_width == 6'd30 && bus.cnt_pixel == 4'd3) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40000) abort_run("reach_30_30");
    @(posedge clk); #3;
    reset = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    n_hs = 0;
    n_done = 0;

    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    rand_bp = 1'b1;
    push_frame();
    pulse_ready();
    repeat (5000) @(posedge clk);
    pulse_ready();
    cyc = 0;
    while (n_done == 0 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 80000) abort_run("frame_done");
    repeat (3) @(posedge clk);
    #2;
    chk("handshakes", 64'(n_hs), 4096);
    chk("done_pulses", 64'(n_done), 1);
    chk("queue_empty", 64'(exp_q.size()), 0);
    chk("idle_busy", bus.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencer for the two-kernel 3x3 convolution MAC on the 64x64 input image. It walks output positions in raster order and issues the valid window taps to the synchronous pixel memory. It packs the returned pixels into the MAC's `pi0`/`pi1`/`pi2` operands and drives the MAC's `cnt_pixel`, `cnt_length`, `cnt_width` and edge-flag controls. It also hands each finished result slot to the writeback stage through a valid/ready handshake.

## Interface
- `IMG_LOG2`, default 6: image side = 2^IMG_LOG2. Only 6 is supported, because the MAC decodes edge positions 0 and 63.
- `DATA_W`, default 16: pixel width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ready`  in  1  start request; sampled only in IDLE.
- `busy`  out  1  frame in progress.
- `iaddr`  out  12  pixel memory address = {row, col}.
- `idata`  in  16  pixel memory read data, valid the cycle after `iaddr`.
- `cnt_pixel`  out  4  number of taps delivered so far for the current position; 0 when idle.
- `pi0`, `pi1`, `pi2`  out  16 each  MAC operand slots.
- `cnt_length`  out  6  current output row.
- `cnt_width`  out  6  current output column.
- `flag_corner`, `flag_upbot`, `flag_lfri`  out  1 each  position class for the MAC.
- `conv_valid`  out  1  MAC results for `conv_addr` are valid.
- `conv_addr`  out  12  {cnt_length, cnt_width}.
- `out_ready`  in  1  writeback accepts the result.
- `done`  out  1  one-cycle pulse at end of frame.

## Operation
- **Reset values:** all outputs are 0; FSM is in IDLE; row and column are 0.
- **FSM:** IDLE → FETCH → DRAIN → LATCH → OUT → (FETCH of next position | DONE) → IDLE.
- **IDLE:** `ready`=1 moves to FETCH with row=col=0 and sets `busy`.
- **Position class** (fixed for the whole position):
  - corner (row ∈ {0,63} and col ∈ {0,63}): `flag_corner`=1, N=4 taps.
  - top or bottom row, not a corner: `flag_upbot`=1, N=6.
  - left or right column, not a corner: `flag_lfri`=1, N=6.
  - interior: all flags 0, N=9.
- **Tap order:** column-major over the valid window positions.
  - Kernel columns are visited left to right; within a column, rows top to bottom.
  - Out-of-image taps are skipped entirely, not zero-filled.
  - Tap (dr, dc) reads address {row+dr, col+dc}.
- **FETCH:** issue tap k=1..N on `iaddr`, one tap per cycle. After tap N, move to DRAIN.
- **Capture:** from the second FETCH cycle through DRAIN, capture `idata` of tap k-1 or N. On that edge:
  - write it into slot `pi[(k-1) mod 3]`;
  - register `cnt_pixel` <= k.
  - Untouched slots hold their value.
- **LATCH:** one cycle in which `cnt_pixel`=N is visible; the MAC latches its final partial product at the end of this cycle. On exit, `cnt_pixel` <= 0.
- **OUT:** `conv_valid`=1 with `conv_addr`.
  - Hold the state while `out_ready`=0; `cnt_pixel` stays 0, so the MAC's registers hold.
  - On `out_ready`=1: advance col; on col wrap 63→0, advance row.
  - After the position (63,63), go to DONE instead.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- `cnt_length`, `cnt_width` and the flags stay stable from the first FETCH cycle through the OUT handshake.
- `ready` is ignored while `busy`=1.
- `reset` asserted mid-frame returns to the reset state immediately; there is no resume.

## Timing
- **Per position:** N FETCH + 1 DRAIN + 1 LATCH + ≥1 OUT cycles. That is 12 cycles for an interior position and 7 for a corner, with no backpressure.
- `cnt_pixel`=k is visible 2 cycles after tap k's `iaddr` cycle.
- `conv_valid` rises the cycle after LATCH.
- `iaddr` is 0 outside FETCH.

## Test plan
- **Interior (5,7):**
  - `iaddr` sequence 262, 326, 390, 263, 327, 391, 264, 328, 392.
  - `cnt_pixel` reaches 3/6/9 with pi0..pi2 = pixels of column 6/7/8.
  - `conv_addr`=327 with all flags 0.
- **Upper-left (0,0):**
  - `iaddr` 0, 64, 1, 65; `flag_corner`=1.
  - `cnt_pixel`=3 with pi0..pi2 = pixels 0/64/1, then `cnt_pixel`=4 with pi0 = pixel 65.
- **Bottom edge (63,10):** `flag_upbot`=1; `iaddr` 3977, 4041, 3978, 4042, 3979, 4043; `cnt_pixel` ends at 6.
- **Backpressure:** `out_ready`=0 for 5 cycles at (2,2) -> `conv_valid` held, `cnt_pixel`=0, no `iaddr` issued; the handshake then advances to (2,3).
- **Full frame** with `out_ready`=1:
  - exactly 4096 `conv_valid` handshakes at addresses 0..4095 in order;
  - `done` pulses once;
  - a `ready` pulse mid-frame is ignored.
- **Reset mid-frame** at position (30,30) -> all outputs 0 asynchronously; the next `ready` restarts from address 0.
